// File: rtl/cache_way_ctrl.sv
// Two-way set-associative tag/data controller with LRU replacement
// and a req/ack line fill, feeding an external 2:1 way mux.
module cache_way_ctrl #(
  parameter int DATA_W  = 3,
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              way_sel,
  output logic [DATA_W-1:0] way0_data,
  output logic [DATA_W-1:0] way1_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hit_q, hit_d;
  logic              victim_q, victim_d;
  logic              way_sel_q, way_sel_d;
  logic [DATA_W-1:0] way0_q, way0_d;
  logic [DATA_W-1:0] way1_q, way1_d;
  logic [SETS-1:0]   lru_q, lru_d;

  logic [1:0]        valid_q [SETS];
  logic [1:0]        valid_d [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][2];
  logic [TAG_W-1:0]  tag_d   [SETS][2];
  logic [DATA_W-1:0] data_q  [SETS][2];
  logic [DATA_W-1:0] data_d  [SETS][2];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit0, hit1, hway;

  assign idx  = addr_q[INDEX_W-1:0];
  assign tag  = addr_q[ADDR_W-1:INDEX_W];
  assign hit0 = valid_q[idx][0] && (tag_q[idx][0] == tag);
  assign hit1 = valid_q[idx][1] && (tag_q[idx][1] == tag);
  assign hway = !hit0;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    hit_d     = hit_q;
    victim_d  = victim_q;
    way_sel_d = way_sel_q;
    way0_d    = way0_q;
    way1_d    = way1_q;
    lru_d     = lru_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end
      state_q == S_LOOKUP: begin
        if (hit0 || hit1) begin
          hit_d     = 1'b1;
          way_sel_d = hway;
          if (we_q) data_d[idx][hway] = wdata_q;
          lru_d[idx] = ~hway;
          way0_d     = data_d[idx][0];
          way1_d     = data_d[idx][1];
          state_d    = S_RESP;
        end else begin
          hit_d    = 1'b0;
          victim_d = !valid_q[idx][0] ? 1'b0 :
                     !valid_q[idx][1] ? 1'b1 : lru_q[idx];
          state_d  = S_FILL;
        end
      end
      state_q == S_FILL: begin
        if (mem_ack) begin
          valid_d[idx][victim_q] = 1'b1;
          tag_d[idx][victim_q]   = tag;
          data_d[idx][victim_q]  = we_q ? wdata_q : mem_rdata;
          lru_d[idx] = ~victim_q;
          way_sel_d  = victim_q;
          way0_d     = data_d[idx][0];
          way1_d     = data_d[idx][1];
          state_d    = S_RESP;
        end
      end
      state_q == S_RESP: state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      hit_q     <= 1'b0;
      victim_q  <= 1'b0;
      way_sel_q <= 1'b0;
      way0_q    <= '0;
      way1_q    <= '0;
      lru_q     <= '0;
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= '0;
        for (int w = 0; w < 2; w++) begin
          tag_q[i][w]  <= '0;
          data_q[i][w] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      hit_q     <= hit_d;
      victim_q  <= victim_d;
      way_sel_q <= way_sel_d;
      way0_q    <= way0_d;
      way1_q    <= way1_d;
      lru_q     <= lru_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
    end
  end

  // mem_req is pure state decode so an async reset drops it at once
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_hit   = resp_valid && hit_q;
  assign mem_req    = (state_q == S_FILL);
  assign mem_addr   = addr_q;
  assign way_sel    = way_sel_q;
  assign way0_data  = way0_q;
  assign way1_data  = way1_q;

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Scoreboard bench for cache_way_ctrl: directed transactions push
// expected responses; a monitor pops and compares on resp_valid.
module tb_cache_way_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_addr = '0;
  logic       req_we = 1'b0;
  logic [2:0] req_wdata = '0;
  logic       resp_valid, resp_hit, way_sel;
  logic [2:0] way0_data, way1_data;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [2:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       hit;
    logic       sel;
    logic [2:0] w0;
    logic [2:0] w1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  cache_way_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .way_sel(way_sel),
    .way0_data(way0_data), .way1_data(way1_data),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_hit", 32'(resp_hit), 32'(mon_e.hit));
        chk("way_sel", 32'(way_sel), 32'(mon_e.sel));
        chk("way0_data", 32'(way0_data), 32'(mon_e.w0));
        chk("way1_data", 32'(way1_data), 32'(mon_e.w1));
      end
    end
  end

  task automatic txn(input logic [7:0] addr, input logic we,
                     input logic [2:0] wd, input logic [2:0] rd,
                     input int ack_dly, input logic e_hit,
                     input logic e_sel, input logic [2:0] e_w0,
                     input logic [2:0] e_w1);
    int  n = 0;
    int  reqcyc = 0;
    bit  got = 0;
    sb.push_back('{e_hit, e_sel, e_w0, e_w1});
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_addr  = addr;
    req_we    = we;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      mem_ack = 1'b0;
      if (resp_valid) begin
        got = 1;
      end else if (mem_req) begin
        reqcyc++;
        chk("mem_addr", 32'(mem_addr), 32'(addr));
        if (reqcyc == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
      end
    end
    mem_ack = 1'b0;
    chk("resp_seen", 32'(got), 32'd1);
    if (!got && sb.size() != 0) void'(sb.pop_back());
    if (e_hit) begin
      chk("hit_latency", 32'(n), 32'd2);
      chk("hit_no_memreq", 32'(reqcyc), 32'd0);
    end else begin
      chk("miss_latency", 32'(n), 32'(2 + ack_dly));
      chk("memreq_cycles", 32'(reqcyc), 32'(ack_dly));
    end
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_way_sel", 32'(way_sel), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_way0", 32'(way0_data), 32'd0);
    chk("rst_way1", 32'(way1_data), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;

    // cold miss, then hit, then LRU sequence on set 1
    txn(8'h15, 0, 3'd0, 3'b101, 3, 0, 0, 3'b101, 3'b000);
    txn(8'h15, 0, 3'd0, 3'b000, 1, 1, 0, 3'b101, 3'b000);
    txn(8'h25, 0, 3'd0, 3'b011, 1, 0, 1, 3'b101, 3'b011);
    txn(8'h15, 0, 3'd0, 3'b000, 1, 1, 0, 3'b101, 3'b011);
    txn(8'h35, 0, 3'd0, 3'b110, 2, 0, 1, 3'b101, 3'b110);
    txn(8'h15, 0, 3'd0, 3'b000, 1, 1, 0, 3'b101, 3'b110);
    txn(8'h25, 0, 3'd0, 3'b011, 1, 0, 1, 3'b101, 3'b011);
    // write hit, write miss (wdata wins over fill), read back
    txn(8'h15, 1, 3'b010, 3'b000, 1, 1, 0, 3'b010, 3'b011);
    txn(8'h09, 1, 3'b111, 3'b000, 2, 0, 1, 3'b010, 3'b111);
    txn(8'h09, 0, 3'd0, 3'b000, 1, 1, 1, 3'b010, 3'b111);
    // tag 0 on an invalid set must still miss
    txn(8'h02, 0, 3'd0, 3'b100, 1, 0, 0, 3'b100, 3'b000);

    // reset in the middle of a fill
    @(negedge clk);
    req_addr  = 8'h16;
    req_we    = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w = 0;
    while (!mem_req && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("fill_started", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 3'b111;
    #1;
    chk("rst_drops_memreq", 32'(mem_req), 32'd0);
    chk("rst_no_resp", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    reset   = 1'b0;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_way0", 32'(way0_data), 32'd0);
    txn(8'h15, 0, 3'd0, 3'b001, 1, 0, 0, 3'b001, 3'b000);
    txn(8'h16, 0, 3'd0, 3'b010, 1, 0, 0, 3'b010, 3'b000);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
